// File: rtl/audio_adc_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : audio_adc_conditioner
// Brief    : MCP3202 12-bit sample conditioner -> signed 16-bit PCM
//            (box decimation, DC removal, saturation, fixed-rate hold)
// Revision : 1.0 - initial release
// ============================================================================
module audio_adc_conditioner #(
  parameter int CLK_FREQ   = 135_000_000,
  parameter int OUT_RATE   = 48_000,
  parameter int DECIM_LOG2 = 3,
  parameter int DC_SHIFT   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [11:0] sample_in,
  output logic [15:0] pcm_out,
  output logic        pcm_strobe,
  output logic        overrun
);

  localparam int c_DIV   = CLK_FREQ / OUT_RATE;
  localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_ACC_W = 12 + DECIM_LOG2;
  localparam int c_DC_W  = 12 + DC_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILTER  = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  logic signed [11:0]        w_s;
  logic signed [c_ACC_W-1:0] w_acc_sum;
  logic signed [c_ACC_W-1:0] r_acc;
  logic [DECIM_LOG2-1:0]     r_dec_cnt;
  logic signed [11:0]        r_avg;
  logic                      r_go;
  state_t                    r_state;
  state_t                    w_state_next;
  logic signed [c_DC_W-1:0]  r_dc_acc;
  logic signed [c_DC_W-1:0]  w_dc_next;
  logic signed [11:0]        w_dc_q;
  logic signed [12:0]        w_hp;
  logic signed [12:0]        r_hp;
  logic signed [16:0]        w_hp_sh;
  logic [15:0]               w_hp_sat;
  logic [15:0]               r_hp_reg;
  logic                      r_fresh;
  logic [c_DIV_W-1:0]        r_div_cnt;
  logic                      w_div_wrap;

  // Offset binary to two's complement: flipping the MSB maps 0x800 to zero.
  assign w_s       = {~sample_in[11], sample_in[10:0]};
  assign w_acc_sum = r_acc + {{DECIM_LOG2{w_s[11]}}, w_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_dec_cnt <= '0;
      r_avg     <= '0;
      r_go      <= 1'b0;
    end else if (!enable) begin
      r_acc     <= '0;
      r_dec_cnt <= '0;
      r_go      <= 1'b0;
    end else begin
      r_go <= 1'b0;
      if (sample_valid) begin
        if (&r_dec_cnt) begin
          // Upper slice of the sum is the arithmetic shift by DECIM_LOG2.
          r_avg     <= w_acc_sum[c_ACC_W-1:DECIM_LOG2];
          r_acc     <= '0;
          r_dec_cnt <= '0;
          r_go      <= 1'b1;
        end else begin
          r_acc     <= w_acc_sum;
          r_dec_cnt <= r_dec_cnt + DECIM_LOG2'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (r_go) w_state_next = S_FILTER;
      S_FILTER:  w_state_next = S_PUBLISH;
      S_PUBLISH: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (!enable) w_state_next = S_IDLE;
  end

  assign w_dc_q    = r_dc_acc[c_DC_W-1:DC_SHIFT];
  assign w_hp      = {r_avg[11], r_avg} - {w_dc_q[11], w_dc_q};
  assign w_dc_next = r_dc_acc + {{DC_SHIFT{r_avg[11]}}, r_avg}
                   - {{DC_SHIFT{w_dc_q[11]}}, w_dc_q};
  assign w_hp_sh   = {r_hp, 4'b0000};
  // The shifted value fits 16 bits only when its top two bits agree.
  assign w_hp_sat  = (w_hp_sh[16] == w_hp_sh[15]) ? w_hp_sh[15:0]
                   : (w_hp_sh[16] ? 16'h8000 : 16'h7FFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dc_acc <= '0;
      r_hp     <= '0;
      r_hp_reg <= '0;
      r_fresh  <= 1'b0;
      overrun  <= 1'b0;
    end else if (!enable) begin
      r_hp_reg <= '0;
      r_fresh  <= 1'b0;
    end else begin
      if (w_div_wrap) r_fresh <= 1'b0;
      case (r_state)
        S_FILTER: begin
          r_dc_acc <= w_dc_next;
          r_hp     <= w_hp;
        end
        S_PUBLISH: begin
          r_hp_reg <= w_hp_sat;
          r_fresh  <= 1'b1;
          if (r_fresh && !w_div_wrap) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobe and pcm_out are registered together so they change on the same cycle.
  assign w_div_wrap = (r_div_cnt == c_DIV_W'(c_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt  <= '0;
      pcm_strobe <= 1'b0;
      pcm_out    <= '0;
    end else begin
      pcm_strobe <= w_div_wrap;
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        pcm_out   <= r_hp_reg;
      end else begin
        r_div_cnt <= r_div_cnt + c_DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_adc_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_adc_conditioner
// Brief    : Directed, table-driven bench for audio_adc_conditioner
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_adc_conditioner;

  localparam int T_DIV   = 64;
  localparam int DEF_DIV = 2812;

  logic        clk = 1'b0;
  logic        reset, enable, sample_valid;
  logic [11:0] sample_in;
  logic [15:0] pcm_out;
  logic        pcm_strobe, overrun;

  logic        rst_def, en_def, sv_def;
  logic [11:0] si_def;
  logic [15:0] pcm_out_def;
  logic        pcm_strobe_def, overrun_def;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  audio_adc_conditioner #(
    .CLK_FREQ(6400), .OUT_RATE(100), .DECIM_LOG2(3), .DC_SHIFT(4)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_in(sample_in), .pcm_out(pcm_out), .pcm_strobe(pcm_strobe), .overrun(overrun)
  );

  audio_adc_conditioner u_dut_def (
    .clk(clk), .reset(rst_def), .enable(en_def), .sample_valid(sv_def),
    .sample_in(si_def), .pcm_out(pcm_out_def), .pcm_strobe(pcm_strobe_def),
    .overrun(overrun_def)
  );

  typedef struct {
    bit          do_rst;
    logic [11:0] code_a;   // first four samples of the block
    logic [11:0] code_b;   // last four samples of the block
    logic [15:0] exp_pcm;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * T_DIV; i++) begin
      @(negedge clk);
      if (pcm_strobe) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no strobe within %0d cycles", tag, 2 * T_DIV);
    end
  endtask

  task automatic feed_block(input logic [11:0] a, input logic [11:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      enable       = 1'b1;
      sample_valid = 1'b1;
      sample_in    = (i < 4) ? a : b;
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    bit  first;
    bit  mono_ok;
    int  prev;

    vecs[0]  = '{1'b1, 12'hC00, 12'hC00, 16'h4000};
    vecs[1]  = '{1'b0, 12'hC00, 12'hC00, 16'h3C00};
    vecs[2]  = '{1'b0, 12'h800, 12'h800, 16'hF840};
    vecs[3]  = '{1'b1, 12'h000, 12'h000, 16'h8000};
    vecs[4]  = '{1'b0, 12'hFFF, 12'hFFF, 16'h7FFF};
    vecs[5]  = '{1'b1, 12'hFFF, 12'hFFF, 16'h7FF0};
    vecs[6]  = '{1'b0, 12'h000, 12'h000, 16'h8000};
    vecs[7]  = '{1'b0, 12'h801, 12'h801, 16'h0090};
    vecs[8]  = '{1'b0, 12'h7FF, 12'h7FF, 16'h0070};
    vecs[9]  = '{1'b1, 12'h7FF, 12'h800, 16'hFFF0};
    vecs[10] = '{1'b1, 12'hA00, 12'h900, 16'h1800};

    reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; sample_in = 12'h800;
    rst_def = 1'b1; en_def = 1'b1; sv_def = 1'b0; si_def = 12'h800;
    repeat (3) @(negedge clk);
    check("rst_pcm_out", {16'h0, pcm_out}, 32'h0);
    check("rst_strobe", {31'h0, pcm_strobe}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    reset   = 1'b0;
    rst_def = 1'b0;

    // Default-parameter instance: strobe spacing with no samples at all.
    n = 0; seen = 1'b0;
    for (int i = 0; i < DEF_DIV + 200; i++) begin
      @(negedge clk); n++;
      if (pcm_strobe_def) begin seen = 1'b1; break; end
    end
    check("def_first_strobe_cycles", n, DEF_DIV);
    n = 0;
    for (int i = 0; i < DEF_DIV + 200; i++) begin
      @(negedge clk); n++;
      if (pcm_strobe_def) break;
    end
    check("def_strobe_period", n, DEF_DIV);
    check("def_pcm_out", {16'h0, pcm_out_def}, 32'h0);
    check("def_overrun", {31'h0, overrun_def}, 32'h0);

    // Block-level vectors; dc_acc carries over between entries without reset.
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].do_rst) begin
        do_reset();
        wait_strobe($sformatf("vec%0d_sync", v));
      end
      feed_block(vecs[v].code_a, vecs[v].code_b);
      wait_strobe($sformatf("vec%0d_strobe", v));
      check($sformatf("vec%0d_pcm_out", v), {16'h0, pcm_out}, {16'h0, vecs[v].exp_pcm});
    end

    // DC removal: constant input decays toward zero, positive and non-increasing.
    do_reset();
    wait_strobe("dc_sync");
    first = 1'b1; mono_ok = 1'b1; prev = 0;
    for (int i = 0; i < 768; i++) begin
      @(negedge clk);
      if (pcm_strobe) begin
        if ($signed(pcm_out) <= 0 || (!first && $signed(pcm_out) > prev)) begin
          mono_ok = 1'b0;
          $display("FAIL dc_monotonic: got %h previous %h", pcm_out, prev[15:0]);
        end
        prev  = $signed(pcm_out);
        first = 1'b0;
      end
      sample_valid = 1'b1;
      sample_in    = 12'hA00;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    check("dc_monotonic_seen", {31'h0, (mono_ok && !first)}, 32'h1);
    wait_strobe("dc_final");
    checks++;
    if ($signed(pcm_out) < 0 || $signed(pcm_out) >= 16'sh0100) begin
      errors++;
      $display("FAIL dc_residual: got %h expected 0000..00FF", pcm_out);
    end

    // Two publishes between strobes set the sticky overrun flag.
    do_reset();
    wait_strobe("ovr_sync");
    feed_block(12'hC00, 12'hC00);
    feed_block(12'hC00, 12'hC00);
    check("ovr_after_one_publish", {31'h0, overrun}, 32'h0);
    repeat (6) @(negedge clk);
    check("ovr_after_two_publish", {31'h0, overrun}, 32'h1);
    wait_strobe("ovr_strobe1");
    check("ovr_pcm_out", {16'h0, pcm_out}, 32'h3C00);
    wait_strobe("ovr_strobe2");
    check("ovr_sticky", {31'h0, overrun}, 32'h1);
    check("underrun_repeat", {16'h0, pcm_out}, 32'h3C00);
    reset = 1'b1;
    #1;
    check("async_rst_overrun", {31'h0, overrun}, 32'h0);
    check("async_rst_pcm_out", {16'h0, pcm_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // PUBLISH lands on the strobe decision cycle: strobe takes the older value.
    do_reset();
    wait_strobe("col_sync");
    feed_block(12'hC00, 12'hC00);
    repeat (43) @(negedge clk);
    feed_block(12'h900, 12'h900);
    wait_strobe("col_strobe1");
    check("col_pcm_old", {16'h0, pcm_out}, 32'h4000);
    check("col_overrun1", {31'h0, overrun}, 32'h0);
    wait_strobe("col_strobe2");
    check("col_pcm_new", {16'h0, pcm_out}, 32'h0C00);
    check("col_overrun2", {31'h0, overrun}, 32'h0);

    // Enable drop mid-block flushes the partial accumulation.
    do_reset();
    wait_strobe("en_sync");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = 12'hFFF;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    enable       = 1'b0;
    repeat (2) @(negedge clk);
    feed_block(12'h900, 12'h900);
    wait_strobe("en_strobe1");
    check("en_flush_pcm_out", {16'h0, pcm_out}, 32'h1000);
    feed_block(12'hC00, 12'hC00);
    repeat (11) @(negedge clk);
    enable = 1'b0;
    wait_strobe("en_low_strobe");
    check("en_low_silence", {16'h0, pcm_out}, 32'h0);
    enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
